// File: rtl/ex_pkg.sv
// ex_pkg: shared constants and bus layouts for the execute stage.
//   - Stage bus widths, stall-vector encoding, SPECIAL func codes.
//   - ALU operation bit positions inside the 12-bit one-hot alu_op.
//   - Divider state encoding.
//   - Packed structs mirroring the decode->EX and EX->MEM buses.
package ex_pkg;

    localparam int STALL_WD     = 6;
    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // SPECIAL (opcode 0) function codes decoded locally in EX
    localparam logic [5:0] FUNC_DIV  = 6'b011010;
    localparam logic [5:0] FUNC_DIVU = 6'b011011;
    localparam logic [5:0] FUNC_MFHI = 6'b010000;
    localparam logic [5:0] FUNC_MFLO = 6'b010010;
    localparam logic [5:0] FUNC_MTHI = 6'b010001;
    localparam logic [5:0] FUNC_MTLO = 6'b010011;

    // Bit positions of each operation in the one-hot alu_op vector
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;            // 158:127
        logic [31:0] inst;          // 126:95
        logic [11:0] alu_op;        // 94:83
        logic [2:0]  sel_alu_src1;  // 82:80
        logic [3:0]  sel_alu_src2;  // 79:76
        logic        data_ram_en;   // 75
        logic [3:0]  data_ram_wen;  // 74:71
        logic        rf_we;         // 70
        logic [4:0]  rf_waddr;      // 69:65
        logic        sel_rf_res;    // 64
        logic [31:0] rdata1;        // 63:32
        logic [31:0] rdata2;        // 31:0
    } id_to_ex_t;

    typedef struct packed {
        logic [31:0] pc;            // 75:44
        logic        data_ram_en;   // 43
        logic [3:0]  data_ram_wen;  // 42:39
        logic        sel_rf_res;    // 38
        logic        rf_we;         // 37
        logic [4:0]  rf_waddr;      // 36:32
        logic [31:0] ex_result;     // 31:0
    } ex_to_mem_t;

endpackage

// File: rtl/ex_if.sv
// ex_if: groups the execute stage's pipeline and data-SRAM signals.
//   stall           : per-stage hold vector (bit 2 = EX, bit 3 = MEM)
//   id_to_ex_bus    : decode -> EX bus (159 bits)
//   ex_to_mem_bus   : EX -> MEM bus (76 bits)
//   ex_to_id_bus    : copy of ex_to_mem_bus for forwarding into decode
//   data_sram_*     : data RAM request (enable, byte writes, address, data)
//   stallreq        : divider-busy hold request
// modport master: the execute stage. modport slave: its surroundings.
interface ex_if;
    import ex_pkg::*;

    logic [STALL_WD-1:0]     stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_id_bus;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;
    logic                    stallreq;

    modport master (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_id_bus,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output stallreq
    );

    modport slave (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_id_bus,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  stallreq
    );

endinterface

// File: rtl/ex_alu.sv
// alu: purely combinational 32-bit ALU driven by a one-hot operation vector.
//   alu_control in 12 : one-hot operation select (positions from ex_pkg)
//   alu_src1    in 32 : operand 1 (shift amount for shifts)
//   alu_src2    in 32 : operand 2 (value shifted / LUI immediate)
//   alu_result  out 32: selected result
module alu
    import ex_pkg::*;
(
    input  logic [11:0] alu_control,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);

    logic [31:0] add_res, sub_res, slt_res, sltu_res;
    logic [31:0] sll_res, srl_res, sra_res, lui_res;

    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
    assign sltu_res = {31'd0, alu_src1 < alu_src2};
    assign sll_res  = alu_src2 << alu_src1[4:0];
    assign srl_res  = alu_src2 >> alu_src1[4:0];
    assign sra_res  = $signed(alu_src2) >>> alu_src1[4:0];
    assign lui_res  = {alu_src2[15:0], 16'd0};

    // One-hot select as an AND-OR tree: no priority chain.
    assign alu_result = ({32{alu_control[ALU_ADD]}}  & add_res)
                      | ({32{alu_control[ALU_SUB]}}  & sub_res)
                      | ({32{alu_control[ALU_SLT]}}  & slt_res)
                      | ({32{alu_control[ALU_SLTU]}} & sltu_res)
                      | ({32{alu_control[ALU_AND]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_control[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_control[ALU_OR]}}   & (alu_src1 | alu_src2))
                      | ({32{alu_control[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_control[ALU_SLL]}}  & sll_res)
                      | ({32{alu_control[ALU_SRL]}}  & srl_res)
                      | ({32{alu_control[ALU_SRA]}}  & sra_res)
                      | ({32{alu_control[ALU_LUI]}}  & lui_res);

endmodule

// File: rtl/ex_div_iter.sv
// div_iter: 32-step restoring divider, signed or unsigned.
//   clk, rst    : clock, synchronous active-high reset
//   start       : a divide is waiting (sampled in IDLE)
//   is_signed   : 1 = DIV, 0 = DIVU
//   dividend    : rs value
//   divisor     : rt value
//   ack         : result consumed, DONE may return to IDLE
//   busy        : iterating (RUN)
//   done        : result valid (DONE)
//   quotient    : sign-corrected quotient (0xFFFFFFFF on divide by zero)
//   remainder   : sign-corrected remainder (dividend on divide by zero)
module div_iter
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state, state_next;
    logic [5:0]  cnt;
    logic [31:0] quo_r, rem_r, dvs_r;
    logic        q_neg_r, r_neg_r, dvs_zero_r;
    logic        dvd_neg, dvs_neg;
    logic [32:0] shifted, diff;

    assign dvd_neg = is_signed & dividend[31];
    assign dvs_neg = is_signed & divisor[31];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values present before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            DIV_IDLE: if (start) state_next = DIV_RUN;
            DIV_RUN: begin
                busy = 1'b1;
                if (cnt == 6'd31) state_next = DIV_DONE;
            end
            DIV_DONE: begin
                done = 1'b1;
                // Holding here while the stage is stalled keeps the same
                // divide from being started a second time.
                if (ack) state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase
    end

    // Partial remainder shifted left by one with the next dividend bit.
    // Since rem_r < dvs_r, a borrow in bit 32 means "does not fit".
    assign shifted = {rem_r, quo_r[31]};
    assign diff    = shifted - {1'b0, dvs_r};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            quo_r      <= '0;
            rem_r      <= '0;
            dvs_r      <= '0;
            q_neg_r    <= 1'b0;
            r_neg_r    <= 1'b0;
            dvs_zero_r <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            // quo_r starts as |dividend| and is shifted out MSB first while
            // quotient bits shift in from the bottom.
            cnt        <= '0;
            quo_r      <= dvd_neg ? -dividend : dividend;
            rem_r      <= '0;
            dvs_r      <= dvs_neg ? -divisor : divisor;
            q_neg_r    <= dvd_neg ^ dvs_neg;
            r_neg_r    <= dvd_neg;
            dvs_zero_r <= (divisor == 32'd0);
        end else if (state == DIV_RUN) begin
            cnt <= cnt + 6'd1;
            if (!diff[32]) begin
                rem_r <= diff[31:0];
                quo_r <= {quo_r[30:0], 1'b1};
            end else begin
                rem_r <= shifted[31:0];
                quo_r <= {quo_r[30:0], 1'b0};
            end
        end
    end

    // A zero divisor leaves all-ones in quo_r and |dividend| in rem_r; the
    // quotient must not be negated in that case, the remainder still is.
    assign quotient  = dvs_zero_r ? {32{1'b1}} : (q_neg_r ? -quo_r : quo_r);
    assign remainder = r_neg_r ? -rem_r : rem_r;

endmodule

// File: rtl/ex.sv
// ex: execute stage of the 5-stage MIPS pipeline.
//   clk  : pipeline clock
//   rst  : synchronous active-high reset
//   bus  : ex_if.master -- stall vector and decode bus in; EX->MEM bus,
//          forwarding copy, data-SRAM request and stallreq out.
// Registers the decode bus, selects ALU operands, runs the ALU, issues the
// data-RAM request, owns HI/LO and the iterative divider.
module ex
    import ex_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ex_if.master     bus
);

    id_to_ex_t   id_r;
    logic        ex_go;
    logic [31:0] imm_sext, imm_zext, sa_zext;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        is_special;
    logic        inst_div, inst_divu, inst_mfhi, inst_mflo, inst_mthi, inst_mtlo;
    logic        is_div;
    logic        div_busy, div_done;
    logic [31:0] div_quo, div_rem;
    logic [31:0] hi, lo;
    logic        stallreq;
    ex_to_mem_t  ex_out;
    logic        unused_bits;

    assign ex_go = (bus.stall[2] == NO_STOP);

    // Input register: bubble when EX holds but MEM moves on, load when EX
    // moves, otherwise keep the current instruction.
    always_ff @(posedge clk) begin
        if (rst)
            id_r <= '0;
        else if (bus.stall[2] == STOP && bus.stall[3] == NO_STOP)
            id_r <= '0;
        else if (ex_go)
            id_r <= bus.id_to_ex_bus;
    end

    // Operand selection (one-hot selects, AND-OR)
    assign imm_sext = {{16{id_r.inst[15]}}, id_r.inst[15:0]};
    assign imm_zext = {16'd0, id_r.inst[15:0]};
    assign sa_zext  = {27'd0, id_r.inst[10:6]};

    assign alu_src1 = ({32{id_r.sel_alu_src1[0]}} & id_r.rdata1)
                    | ({32{id_r.sel_alu_src1[1]}} & id_r.pc)
                    | ({32{id_r.sel_alu_src1[2]}} & sa_zext);

    assign alu_src2 = ({32{id_r.sel_alu_src2[0]}} & id_r.rdata2)
                    | ({32{id_r.sel_alu_src2[1]}} & imm_sext)
                    | ({32{id_r.sel_alu_src2[2]}} & 32'd8)
                    | ({32{id_r.sel_alu_src2[3]}} & imm_zext);

    alu u_alu (
        .alu_control (id_r.alu_op),
        .alu_src1    (alu_src1),
        .alu_src2    (alu_src2),
        .alu_result  (alu_result)
    );

    // Local decode of the HI/LO and divide instructions
    assign is_special = (id_r.inst[31:26] == 6'd0);
    assign inst_div   = is_special && id_r.inst[5:0] == FUNC_DIV;
    assign inst_divu  = is_special && id_r.inst[5:0] == FUNC_DIVU;
    assign inst_mfhi  = is_special && id_r.inst[5:0] == FUNC_MFHI;
    assign inst_mflo  = is_special && id_r.inst[5:0] == FUNC_MFLO;
    assign inst_mthi  = is_special && id_r.inst[5:0] == FUNC_MTHI;
    assign inst_mtlo  = is_special && id_r.inst[5:0] == FUNC_MTLO;
    assign is_div     = inst_div | inst_divu;

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div),
        .is_signed (inst_div),
        .dividend  (id_r.rdata1),
        .divisor   (id_r.rdata2),
        .ack       (ex_go),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // High while a divide waits to start (IDLE) or iterates (RUN).
    assign stallreq = (is_div & ~div_busy & ~div_done) | div_busy;

    // HI/LO change only as the producing instruction leaves EX, so an
    // MFHI/MFLO right behind it already sees the new value.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (ex_go) begin
            if (is_div && div_done) begin
                hi <= div_rem;
                lo <= div_quo;
            end else begin
                if (inst_mthi) hi <= id_r.rdata1;
                if (inst_mtlo) lo <= id_r.rdata1;
            end
        end
    end

    always_comb begin
        ex_out              = '0;
        ex_out.pc           = id_r.pc;
        ex_out.data_ram_en  = id_r.data_ram_en;
        ex_out.data_ram_wen = id_r.data_ram_wen;
        ex_out.sel_rf_res   = id_r.sel_rf_res;
        ex_out.rf_we        = id_r.rf_we | inst_mfhi | inst_mflo;
        ex_out.rf_waddr     = id_r.rf_waddr;
        ex_out.ex_result    = inst_mfhi ? hi : (inst_mflo ? lo : alu_result);
    end

    assign bus.ex_to_mem_bus   = ex_out;
    assign bus.ex_to_id_bus    = ex_out;
    assign bus.stallreq        = stallreq;
    assign bus.data_sram_en    = id_r.data_ram_en & ~stallreq;
    assign bus.data_sram_wen   = id_r.data_ram_wen & {4{~stallreq}};
    assign bus.data_sram_addr  = alu_result;
    assign bus.data_sram_wdata = id_r.rdata2;

    // Bits of the stall vector and instruction word this stage does not use.
    assign unused_bits = ^{bus.stall[5:4], bus.stall[1:0], id_r.inst[25:16]};

endmodule
